// File: rtl/gray_sync_decoder_if.sv
// Bus between a Gray count source and the gray_sync_decoder receive logic.
// The source drives the Gray word and error clear; the decoder returns the
// decoded count and step/error flags.
interface gray_sync_decoder_if #(
    parameter int N = 4
);
    logic [N-1:0] gray_in;
    logic         clr_err;
    logic [N-1:0] bin_out;
    logic         valid;
    logic         dir;
    logic         err;
    logic         err_sticky;

    modport master (
        output gray_in, clr_err,
        input  bin_out, valid, dir, err, err_sticky
    );

    modport slave (
        input  gray_in, clr_err,
        output bin_out, valid, dir, err, err_sticky
    );
endinterface

// File: rtl/gray_sync_decoder.sv
// Gray-coded counter receiver: synchronizes a possibly asynchronous Gray word,
// decodes it to binary and classifies each change as +1, -1 or an illegal jump.
module gray_sync_decoder #(
    parameter int N           = 4,
    parameter int SYNC_STAGES = 2
) (
    input logic                 clk,
    input logic                 rst,
    gray_sync_decoder_if.slave  bus
);

    typedef enum logic {
        S_INIT,
        S_TRACK
    } state_t;

    localparam int           CW        = $clog2(SYNC_STAGES + 1);
    localparam logic [CW-1:0] INIT_LAST = CW'(SYNC_STAGES);
    localparam logic [N-1:0]  ONE       = N'(1);

    logic [N-1:0]  sync_q [SYNC_STAGES];
    logic [N-1:0]  g_s;
    logic [N-1:0]  b;

    state_t        state_q, state_d;
    logic [CW-1:0] init_cnt_q, init_cnt_d;
    logic          init_done;

    logic [N-1:0]  bin_q, bin_d;
    logic [N-1:0]  prev_q, prev_d;
    logic          valid_q, valid_d;
    logic          dir_q, dir_d;
    logic          err_q, err_d;
    logic          sticky_q, sticky_d;

    // Plain flop chain on gray_in; nothing may sit between stages.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every stage samples the pre-edge
        // value of its neighbour; = here would collapse the chain to one flop.
        if (rst) begin
            // NOTE: the chain is a small array but is reset explicitly so a
            // fresh start never decodes leftovers from before reset.
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= bus.gray_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign g_s = sync_q[SYNC_STAGES-1];

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        // NOTE: every bit is assigned on every pass, so no latch is implied.
        b = '0;
        for (int i = 0; i < N; i++) b[i] = ^(g_s >> i);
    end

    // State register and flush counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_INIT;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    assign init_done = (init_cnt_q == INIT_LAST);

    // Next state: wait SYNC_STAGES cycles for the chain to flush, then track.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        case (state_q)
            S_INIT: begin
                if (init_done) state_d    = S_TRACK;
                else           init_cnt_d = init_cnt_q + 1'b1;
            end
            default: state_d = S_TRACK;
        endcase
    end

    // Output decisions: baseline load in INIT, step classification in TRACK.
    always_comb begin
        bin_d   = bin_q;
        prev_d  = prev_q;
        valid_d = 1'b0;
        dir_d   = dir_q;
        err_d   = 1'b0;
        case (state_q)
            S_INIT: begin
                if (init_done) begin
                    bin_d  = b;
                    prev_d = b;
                end
            end
            default: begin
                if (b == prev_q) begin
                    // no movement
                end else if (b == prev_q + ONE) begin
                    valid_d = 1'b1;
                    dir_d   = 1'b1;
                    bin_d   = b;
                    prev_d  = b;
                end else if (b == prev_q - ONE) begin
                    valid_d = 1'b1;
                    dir_d   = 1'b0;
                    bin_d   = b;
                    prev_d  = b;
                end else begin
                    // Illegal jump: flag it and resync to the new value.
                    err_d  = 1'b1;
                    bin_d  = b;
                    prev_d = b;
                end
            end
        endcase
        // Set wins over clear; a clear overlapping the visible err pulse is
        // also ignored so an error is never lost to a coincident clear.
        if (err_d)                     sticky_d = 1'b1;
        else if (bus.clr_err && !err_q) sticky_d = 1'b0;
        else                           sticky_d = sticky_q;
    end

    // Registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q    <= '0;
            prev_q   <= '0;
            valid_q  <= 1'b0;
            dir_q    <= 1'b1;
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            bin_q    <= bin_d;
            prev_q   <= prev_d;
            valid_q  <= valid_d;
            dir_q    <= dir_d;
            err_q    <= err_d;
            sticky_q <= sticky_d;
        end
    end

    assign bus.bin_out    = bin_q;
    assign bus.valid      = valid_q;
    assign bus.dir        = dir_q;
    assign bus.err        = err_q;
    assign bus.err_sticky = sticky_q;

endmodule

// File: doc/gray_sync_decoder.md
Name: gray_sync_decoder

Overview:
- Receive end of a Gray-coded counter bus, typically a free-running Gray counter or a pointer from another clock domain or an external source.
- Synchronizes the Gray word into the local clock domain and decodes it to binary.
- Classifies each change as a legal step up, a legal step down, or an illegal jump.
- Sits between a Gray count source and local consumers such as FIFO pointer compare logic or position tracking.

Parameters:
- N, 4, width of the Gray/binary word (N >= 2).
- SYNC_STAGES, 2, number of synchronizer flops on gray_in (>= 2).

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- gray_in  input  N  Gray-coded count; may be asynchronous to clk.
- clr_err  input  1  pulse; clears err_sticky.
- bin_out  output  N  decoded binary value of the last accepted sample.
- valid  output  1  one-cycle pulse on a legal ±1 step.
- dir  output  1  direction of the last legal step; 1 = up, 0 = down.
- err  output  1  one-cycle pulse on an illegal jump.
- err_sticky  output  1  latched error flag.

Behaviour:
Reset:
- rst is sampled on posedge clk.
- Reset values: sync chain = 0, prev_bin = 0, bin_out = 0, valid = 0, dir = 1, err = 0, err_sticky = 0, state = INIT, init counter = 0.
- rst asserted mid-operation takes effect at the next edge and discards any in-flight sample.

Synchronizer:
- gray_in passes through SYNC_STAGES flops; the last stage is g_s.
- No logic is permitted between synchronizer stages.

Decode (combinational on g_s):
- b[N-1] = g_s[N-1].
- b[i] = b[i+1] ^ g_s[i], for i = N-2 down to 0.

State machine:
- INIT:
  - Counts SYNC_STAGES cycles after reset release so the chain flushes.
  - On the next edge it loads bin_out = b and prev_bin = b, then goes to TRACK.
  - No valid or err pulse in INIT or on the baseline load.
- TRACK, evaluated every cycle:
  - b == prev_bin: no event; valid = 0, err = 0.
  - b == prev_bin + 1 (mod 2^N): valid = 1, dir = 1, bin_out = b, prev_bin = b.
  - b == prev_bin - 1 (mod 2^N): valid = 1, dir = 0, bin_out = b, prev_bin = b.
  - Any other value:
    - err = 1, valid = 0, err_sticky = 1.
    - Resync: bin_out = b, prev_bin = b.
    - dir is unchanged.

Rules:
- Latency: a stable gray_in change is reflected on bin_out/valid SYNC_STAGES+1 edges after the first edge that samples it.
- Wrap-around: 2^N-1 -> 0 is a legal up-step; 0 -> 2^N-1 is a legal down-step.
- Arithmetic is N-bit modulo; no carry is kept.
- valid and err are mutually exclusive and never high for two consecutive cycles from the same step.
- err_sticky priority: if err and clr_err coincide, err_sticky stays 1 (set wins). clr_err with no error clears err_sticky at the next edge.
- The source must change gray_in by at most one code per SYNC_STAGES+1 clk cycles. Faster movement is reported through err and is not corrected.

Test Plan (N=4, SYNC_STAGES=2):
1. Hold gray_in=0110 (bin 4) through reset, release rst -> bin_out=4 by the 4th edge after release; valid=0 and err=0 throughout.
2. From baseline 0, step gray_in 0001,0011,0010,...,1000,0000, each held 4 cycles -> 16 valid pulses, dir=1, bin_out 1..15 then 0; err never set.
3. Baseline 0, gray_in 0000 -> 1000 -> valid pulse, dir=0, bin_out=15; then 1000 -> 1001 -> bin_out=14, dir=0.
4. Baseline gray 0001 (bin 1), apply 0010 (bin 3) -> err pulse 1 cycle, valid=0, bin_out=3, err_sticky=1. Then pulse clr_err -> err_sticky=0 next edge.
5. Drive an illegal jump so err fires in the same cycle clr_err=1 -> err_sticky remains 1.
6. With bin_out=9 in TRACK, assert rst for 1 cycle while gray_in=1101 -> next edge bin_out=0, valid=0, err_sticky=0. After release, re-baselines to bin_out=9 with no valid or err pulse.
